// File: rtl/isa_pkg.sv
// Shared ALU/branch ISA definitions: opcode encodings, flag bit positions, flag type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package isa_pkg;

   localparam int FLAG_W  = 5;

   // Flag register bit positions
   localparam int FLG_OVF = 0;
   localparam int FLG_ABV = 1;
   localparam int FLG_BLW = 2;
   localparam int FLG_EQ  = 3;
   localparam int FLG_ERR = 4;

   typedef logic [FLAG_W-1:0] flags_t;

   // Opcode encodings shared with the ALU
   localparam logic [4:0] OP_ADD  = 5'b00110;
   localparam logic [4:0] OP_SUB  = 5'b00111;
   localparam logic [4:0] OP_MUL  = 5'b01000;
   localparam logic [4:0] OP_DIV  = 5'b01001;
   localparam logic [4:0] OP_CMP  = 5'b01110;
   localparam logic [4:0] OP_JR   = 5'b10000;
   localparam logic [4:0] OP_JPC  = 5'b10001;
   localparam logic [4:0] OP_BRFL = 5'b10010;
   localparam logic [4:0] OP_CALL = 5'b10011;
   localparam logic [4:0] OP_RET  = 5'b10100;
   localparam logic [4:0] OP_NOP  = 5'b10101;

   // Opcodes whose flags come straight from the ALU flag vector
   function automatic logic is_alu_arith(input logic [4:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/call_stack.sv
// LIFO call/return stack; push/pop ignored when full/empty so contents never corrupt.
// Latency: push/pop take effect on the next rising edge; top is combinational from state.
// Backpressure: none; caller must consult full/empty (illegal requests are dropped).
// Ports: clk, reset (sync, active-high), push/push_dat, pop, full, empty, top (current top entry).
module call_stack #(
   parameter int ADDR_W      = 32,
   parameter int STACK_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_dat,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W-1:0] top
);

   localparam int PTR_W = $clog2(STACK_DEPTH);

   // sp counts occupied entries, so it needs one bit more than the index
   logic [PTR_W:0]      sp_q, sp_d;
   logic [ADDR_W-1:0]   mem_q [STACK_DEPTH];
   logic [ADDR_W-1:0]   mem_d [STACK_DEPTH];
   logic [PTR_W-1:0]    top_idx;

   assign full    = (sp_q == (PTR_W+1)'(STACK_DEPTH));
   assign empty   = (sp_q == '0);
   // Wraps correctly when full: low bits are 0, minus one gives DEPTH-1
   assign top_idx = sp_q[PTR_W-1:0] - PTR_W'(1);
   assign top     = mem_q[top_idx];

   always_comb begin
      sp_d  = sp_q;
      mem_d = mem_q;
      if (push && !full) begin
         mem_d[sp_q[PTR_W-1:0]] = push_dat;
         sp_d = sp_q + (PTR_W+1)'(1);
      end else if (pop && !empty) begin
         sp_d = sp_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         sp_q  <= sp_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/branch_flag_unit.sv
// Flag register, branch/jump/call/return resolution and call stack behind the ALU; one next-PC per op.
// Latency: 1 cycle from accept to res_valid with the registered result.
// Backpressure: op_ready = !res_valid | res_ready; a stalled result is held stable and flags/stack freeze.
// Ports: clk, reset; op_valid/op_ready/op_code/op_a/op_b/pc_in/alu_flags in;
//        res_valid/res_ready, pc_next, taken, flags, stack_err out.
module branch_flag_unit
   import isa_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int STACK_DEPTH = 8,
   parameter int PC_INC      = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [4:0]        op_code,
   input  logic [ADDR_W-1:0] op_a,
   input  logic [ADDR_W-1:0] op_b,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic [4:0]        alu_flags,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ADDR_W-1:0] pc_next,
   output logic              taken,
   output logic [4:0]        flags,
   output logic              stack_err
);

   logic              res_valid_q, res_valid_d;
   logic [ADDR_W-1:0] pc_next_q,   pc_next_d;
   logic              taken_q,     taken_d;
   flags_t            flags_q,     flags_d;
   logic              stack_err_q, stack_err_d;

   logic              accept;
   logic [ADDR_W-1:0] seq_pc;
   logic              stk_push, stk_pop, stk_full, stk_empty;
   logic [ADDR_W-1:0] stk_top;
   logic signed [ADDR_W-1:0] a_s, b_s;

   assign op_ready = !res_valid_q || res_ready;
   assign accept   = op_valid && op_ready;
   assign seq_pc   = pc_in + ADDR_W'(PC_INC);
   assign a_s      = $signed(op_a);
   assign b_s      = $signed(op_b);

   call_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_call_stack (
      .clk      (clk),
      .reset    (reset),
      .push     (stk_push),
      .push_dat (seq_pc),
      .pop      (stk_pop),
      .full     (stk_full),
      .empty    (stk_empty),
      .top      (stk_top)
   );

   always_comb begin
      res_valid_d = res_valid_q && !res_ready;
      pc_next_d   = pc_next_q;
      taken_d     = taken_q;
      flags_d     = flags_q;
      stack_err_d = stack_err_q;
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
      if (accept) begin
         res_valid_d = 1'b1;
         pc_next_d   = seq_pc;
         taken_d     = 1'b0;
         if (is_alu_arith(op_code)) begin
            flags_d = alu_flags;
         end
         case (op_code)
            OP_CMP: begin
               flags_d = '0;
               if (a_s == b_s)     flags_d[FLG_EQ]  = 1'b1;
               else if (a_s > b_s) flags_d[FLG_ABV] = 1'b1;
               else                flags_d[FLG_BLW] = 1'b1;
            end
            OP_JR: begin
               pc_next_d = op_a;
               taken_d   = 1'b1;
            end
            OP_JPC: begin
               // two's-complement add gives the signed offset with natural wrap
               pc_next_d = pc_in + op_b;
               taken_d   = 1'b1;
            end
            OP_BRFL: begin
               // compares against flags as they stood before this op
               if (flags_q == op_b[FLAG_W-1:0]) begin
                  pc_next_d = op_a;
                  taken_d   = 1'b1;
               end
            end
            OP_CALL: begin
               if (!stk_full) begin
                  stk_push  = 1'b1;
                  pc_next_d = op_a;
                  taken_d   = 1'b1;
               end else begin
                  stack_err_d      = 1'b1;
                  flags_d[FLG_ERR] = 1'b1;
               end
            end
            OP_RET: begin
               if (!stk_empty) begin
                  stk_pop   = 1'b1;
                  pc_next_d = stk_top;
                  taken_d   = 1'b1;
               end else begin
                  stack_err_d      = 1'b1;
                  flags_d[FLG_ERR] = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         res_valid_q <= 1'b0;
         pc_next_q   <= '0;
         taken_q     <= 1'b0;
         flags_q     <= '0;
         stack_err_q <= 1'b0;
      end else begin
         res_valid_q <= res_valid_d;
         pc_next_q   <= pc_next_d;
         taken_q     <= taken_d;
         flags_q     <= flags_d;
         stack_err_q <= stack_err_d;
      end
   end

   assign res_valid = res_valid_q;
   assign pc_next   = pc_next_q;
   assign taken     = taken_q;
   assign flags     = flags_q;
   assign stack_err = stack_err_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Testbench for branch_flag_unit: directed scenarios plus randomized ops against a behavioural model.
// Latency: n/a.
// Backpressure: exercises res_ready stalls.
module tb_branch_flag_unit;
   import isa_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic        op_ready;
   logic [4:0]  op_code;
   logic [31:0] op_a, op_b, pc_in;
   logic [4:0]  alu_flags;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] pc_next;
   logic        taken;
   logic [4:0]  flags;
   logic        stack_err;

   branch_flag_unit #(.ADDR_W(32), .STACK_DEPTH(8), .PC_INC(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_code   (op_code),
      .op_a      (op_a),
      .op_b      (op_b),
      .pc_in     (pc_in),
      .alu_flags (alu_flags),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .pc_next   (pc_next),
      .taken     (taken),
      .flags     (flags),
      .stack_err (stack_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state
   logic [4:0]  m_flags;
   logic        m_err;
   logic [31:0] m_stk[$];
   logic [31:0] e_pc;
   logic        e_taken;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_flags = '0;
      m_err   = 1'b0;
      m_stk.delete();
      e_pc    = '0;
      e_taken = 1'b0;
   endtask

   task automatic model_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [4:0] af);
      logic [31:0] seq;
      seq     = pc + 32'd1;
      e_pc    = seq;
      e_taken = 1'b0;
      if (op == OP_ADD || op == OP_SUB || op == OP_MUL || op == OP_DIV) m_flags = af;
      else if (op == OP_CMP) begin
         if ($signed(a) == $signed(b))     m_flags = 5'h08;
         else if ($signed(a) > $signed(b)) m_flags = 5'h02;
         else                              m_flags = 5'h04;
      end else if (op == OP_JR) begin
         e_pc = a; e_taken = 1'b1;
      end else if (op == OP_JPC) begin
         e_pc = pc + b; e_taken = 1'b1;
      end else if (op == OP_BRFL) begin
         if (m_flags == b[4:0]) begin e_pc = a; e_taken = 1'b1; end
      end else if (op == OP_CALL) begin
         if (m_stk.size() < 8) begin
            m_stk.push_back(seq); e_pc = a; e_taken = 1'b1;
         end else begin
            m_err = 1'b1; m_flags[4] = 1'b1;
         end
      end else if (op == OP_RET) begin
         if (m_stk.size() > 0) begin
            e_pc = m_stk.pop_back(); e_taken = 1'b1;
         end else begin
            m_err = 1'b1; m_flags[4] = 1'b1;
         end
      end
   endtask

   task automatic check_outs(input string tag);
      chk({tag, ".res_valid"}, 32'(res_valid), 32'd1);
      chk({tag, ".pc_next"},   pc_next,        e_pc);
      chk({tag, ".taken"},     32'(taken),     32'(e_taken));
      chk({tag, ".flags"},     32'(flags),     32'(m_flags));
      chk({tag, ".stack_err"}, 32'(stack_err), 32'(m_err));
   endtask

   // Offer one op with res_ready high; it is accepted on the next rising edge.
   task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic [4:0] af);
      @(negedge clk);
      op_valid = 1'b1; op_code = op; op_a = a; op_b = b; pc_in = pc; alu_flags = af;
      res_ready = 1'b1;
      #1;
      chk({tag, ".op_ready"}, 32'(op_ready), 32'd1);
      @(posedge clk);
      model_op(op, a, b, pc, af);
      #1;
      check_outs(tag);
      op_valid = 1'b0;
   endtask

   logic [4:0] ops_tbl [12];

   initial begin
      reset = 1'b1; op_valid = 1'b0; op_code = '0; op_a = '0; op_b = '0;
      pc_in = '0; alu_flags = '0; res_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.res_valid", 32'(res_valid), 32'd0);
      chk("rst.pc_next",   pc_next,        32'd0);
      chk("rst.taken",     32'(taken),     32'd0);
      chk("rst.flags",     32'(flags),     32'd0);
      chk("rst.stack_err", 32'(stack_err), 32'd0);
      chk("rst.op_ready",  32'(op_ready),  32'd1);
      @(negedge clk);
      reset = 1'b0;

      // Sequential NOP
      issue("nop", OP_NOP, 32'd0, 32'd0, 32'h10, 5'd0);
      chk("nop.pc_lit", pc_next, 32'h11);

      // CMP then BRFL using the fresh flags
      issue("cmp", OP_CMP, 32'hFFFF_FFFD, 32'd5, 32'h20, 5'd0);
      chk("cmp.flags_lit", 32'(flags), 32'h04);
      issue("brfl_t", OP_BRFL, 32'h200, 32'h04, 32'h21, 5'd0);
      chk("brfl_t.pc_lit", pc_next, 32'h200);
      issue("brfl_n", OP_BRFL, 32'h200, 32'h08, 32'h22, 5'd0);
      chk("brfl_n.pc_lit", pc_next, 32'h23);

      // JPC negative offset and wrap
      issue("jpc_neg", OP_JPC, 32'd0, 32'hFFFF_FFFC, 32'h100, 5'd0);
      chk("jpc_neg.pc_lit", pc_next, 32'hFC);
      issue("jpc_wrap", OP_JPC, 32'd0, 32'd2, 32'hFFFF_FFFF, 5'd0);
      chk("jpc_wrap.pc_lit", pc_next, 32'h1);

      // Fill stack, overflow, drain, underflow
      for (int i = 0; i < 8; i++) issue("call", OP_CALL, 32'h400 + 32'(i), 32'd0, 32'(i), 5'd0);
      issue("call_full", OP_CALL, 32'h500, 32'd0, 32'd8, 5'd0);
      chk("call_full.taken", 32'(taken), 32'd0);
      chk("call_full.err",   32'(stack_err), 32'd1);
      chk("call_full.flag4", 32'(flags[4]), 32'd1);
      for (int k = 0; k < 8; k++) begin
         issue("ret", OP_RET, 32'd0, 32'd0, 32'h50 + 32'(k), 5'd0);
         chk("ret.pc_lit", pc_next, 32'(8 - k));
      end
      issue("ret_empty", OP_RET, 32'd0, 32'd0, 32'h60, 5'd0);
      chk("ret_empty.pc_lit", pc_next, 32'h61);
      chk("ret_empty.taken", 32'(taken), 32'd0);

      // Backpressure: stalled result freezes outputs and flags
      issue("bp_first", OP_NOP, 32'd0, 32'd0, 32'h30, 5'd0);
      @(negedge clk);
      res_ready = 1'b0; op_valid = 1'b1; op_code = OP_CMP;
      op_a = 32'd1; op_b = 32'd0; pc_in = 32'h31; alu_flags = '0;
      #1;
      chk("bp.op_ready", 32'(op_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check_outs("bp_hold");
      chk("bp.op_ready2", 32'(op_ready), 32'd0);
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      model_op(OP_CMP, 32'd1, 32'd0, 32'h31, 5'd0);
      #1;
      check_outs("bp_drain");
      op_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("idle.res_valid", 32'(res_valid), 32'd0);

      // Randomized ops against the model
      ops_tbl = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP, OP_JR, OP_JPC,
                  OP_BRFL, OP_CALL, OP_RET, OP_NOP, 5'd0};
      for (int n = 0; n < 400; n++) begin
         logic [4:0]  op;
         logic [31:0] a, b;
         int          sel;
         sel = int'($urandom_range(0, 11));
         op  = ops_tbl[sel];
         if (sel == 11) op = 5'($urandom);
         a   = $urandom;
         b   = $urandom;
         if ($urandom_range(0, 3) == 0) b = a;
         if (op == OP_BRFL && $urandom_range(0, 1) == 1) b[4:0] = m_flags;
         issue("rnd", op, a, b, $urandom, 5'($urandom));
      end

      // Reset in the middle of a stream with three stacked calls
      @(negedge clk);
      reset = 1'b1;
      #1;
      model_reset();
      @(posedge clk);
      #1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) issue("pre_rst_call", OP_CALL, 32'h700 + 32'(i), 32'd0, 32'(i), 5'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      chk("mrst.res_valid", 32'(res_valid), 32'd0);
      chk("mrst.flags",     32'(flags),     32'd0);
      chk("mrst.stack_err", 32'(stack_err), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      issue("post_rst_ret", OP_RET, 32'd0, 32'd0, 32'h80, 5'd0);
      chk("post_rst_ret.err", 32'(stack_err), 32'd1);
      chk("post_rst_ret.taken", 32'(taken), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
